// File: rtl/pipe_pkg.sv
// Shared pipeline types for the 5-stage core: micro-op enums, the ID/EX bundle,
// RV32 opcode constants and the source-register usage helpers.
package pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0, ALU_SUB  = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR  = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR   = 4'd8, ALU_AND  = 4'd9, ALU_LUI = 4'd10
    } aluop_t;

    typedef enum logic [2:0] {
        LSU_NONE = 3'd0, LSU_LB = 3'd1, LSU_LH = 3'd2, LSU_LW = 3'd3,
        LSU_LBU  = 3'd4, LSU_LHU = 3'd5, LSU_SB = 3'd6, LSU_SW = 3'd7
    } lsuop_t;

    typedef enum logic [2:0] {
        CFU_NONE = 3'd0, CFU_BEQ = 3'd1, CFU_BNE = 3'd2, CFU_BLT = 3'd3,
        CFU_BGE  = 3'd4, CFU_JAL = 3'd5, CFU_JALR = 3'd6
    } cfuop_t;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0, CSR_RW = 2'd1, CSR_RS = 2'd2, CSR_RC = 2'd3
    } csrop_t;

    typedef struct packed {
        logic              valid;
        aluop_t            aluop;
        lsuop_t            lsuop;
        cfuop_t            cfuop;
        csrop_t            csrop;
        logic              rf_en;
        logic              dm_wr_en;
        logic              dm_rd_en;
        logic              csr_wr_en;
        logic              opr_a_sel;
        logic              opr_b_sel;
        logic [1:0]        wb_sel;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rdata1;
        logic [XLEN-1:0]   rdata2;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
    } id_ex_t;

    // Bubble and reset share one encoding: every field zero, enums at their zero value.
    localparam id_ex_t ID_EX_BUBBLE = '0;

    function automatic logic uses_rs1_f(input logic [6:0] opcode);
        logic r;
        case (opcode)
            OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE,
            OPC_BRANCH, OPC_JALR, OPC_SYSTEM: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic uses_rs2_f(input logic [6:0] opcode);
        logic r;
        case (opcode)
            OPC_OP, OPC_STORE, OPC_BRANCH: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use hazard detector: flags an ID instruction that reads the destination
// of a load currently sitting in EX.
module hazard_unit
    import pipe_pkg::*;
(
    input  logic       i_id_valid,
    input  logic [6:0] i_id_opcode,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_ex_valid,
    input  logic       i_ex_dm_rd_en,
    input  logic       i_ex_rf_en,
    input  logic [4:0] i_ex_rd,
    output logic       o_load_use
);

    logic w_ex_is_load;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is never a real destination, so a load to x0 cannot create a hazard.
    always_comb begin
        w_ex_is_load = i_ex_valid & i_ex_dm_rd_en & i_ex_rf_en & (i_ex_rd != 5'd0);
        w_rs1_hit    = uses_rs1_f(i_id_opcode) & (i_id_rs1 == i_ex_rd);
        w_rs2_hit    = uses_rs2_f(i_id_opcode) & (i_id_rs2 == i_ex_rd);
        o_load_use   = i_id_valid & w_ex_is_load & (w_rs1_hit | w_rs2_hit);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold handling
// and a load-use bubble performance counter.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = pipe_pkg::XLEN,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [6:0]        id_opcode,
    input  aluop_t            id_aluop,
    input  lsuop_t            id_lsuop,
    input  cfuop_t            id_cfuop,
    input  csrop_t            id_csrop,
    input  logic              id_rf_en,
    input  logic              id_dm_wr_en,
    input  logic              id_dm_rd_en,
    input  logic              id_csr_wr_en,
    input  logic              id_opr_a_sel,
    input  logic              id_opr_b_sel,
    input  logic [1:0]        id_wb_sel,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              ex_flush,
    input  logic              ex_stall,
    output logic              ex_valid,
    output aluop_t            ex_aluop,
    output lsuop_t            ex_lsuop,
    output cfuop_t            ex_cfuop,
    output csrop_t            ex_csrop,
    output logic              ex_rf_en,
    output logic              ex_dm_wr_en,
    output logic              ex_dm_rd_en,
    output logic              ex_csr_wr_en,
    output logic              ex_opr_a_sel,
    output logic              ex_opr_b_sel,
    output logic [1:0]        ex_wb_sel,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rdata1,
    output logic [XLEN-1:0]   ex_rdata2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic              stall_id,
    output logic [PERF_W-1:0] perf_lu_bubbles
);

    id_ex_t            r_ex;
    id_ex_t            w_id;
    id_ex_t            w_ex_next;
    logic              w_load_use;
    logic              w_lu_inc;
    logic [PERF_W-1:0] r_perf;

    hazard_unit u_hazard (
        .i_id_valid    (id_valid),
        .i_id_opcode   (id_opcode),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_ex_valid    (r_ex.valid),
        .i_ex_dm_rd_en (r_ex.dm_rd_en),
        .i_ex_rf_en    (r_ex.rf_en),
        .i_ex_rd       (r_ex.rd),
        .o_load_use    (w_load_use)
    );

    always_comb begin
        w_id = '{valid: 1'b1, aluop: id_aluop, lsuop: id_lsuop, cfuop: id_cfuop,
                 csrop: id_csrop, rf_en: id_rf_en, dm_wr_en: id_dm_wr_en,
                 dm_rd_en: id_dm_rd_en, csr_wr_en: id_csr_wr_en,
                 opr_a_sel: id_opr_a_sel, opr_b_sel: id_opr_b_sel,
                 wb_sel: id_wb_sel, pc: id_pc, rdata1: id_rdata1,
                 rdata2: id_rdata2, imm: id_imm, rs1: id_rs1, rs2: id_rs2,
                 rd: id_rd};
    end

    // Priority: flush, then hold, then load-use bubble; an empty decode slot loads as a bubble.
    always_comb begin
        w_ex_next = r_ex;
        w_lu_inc  = 1'b0;
        if (ex_flush) begin
            w_ex_next = ID_EX_BUBBLE;
        end else if (ex_stall) begin
            w_ex_next = r_ex;
        end else if (w_load_use) begin
            w_ex_next = ID_EX_BUBBLE;
            w_lu_inc  = 1'b1;
        end else if (id_valid) begin
            w_ex_next = w_id;
        end else begin
            w_ex_next = ID_EX_BUBBLE;
        end
    end

    always_comb begin
        stall_id = ~ex_flush & (ex_stall | w_load_use);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex   <= ID_EX_BUBBLE;
            r_perf <= '0;
        end else begin
            r_ex   <= w_ex_next;
            r_perf <= r_perf + PERF_W'(w_lu_inc);
        end
    end

    assign ex_valid        = r_ex.valid;
    assign ex_aluop        = r_ex.aluop;
    assign ex_lsuop        = r_ex.lsuop;
    assign ex_cfuop        = r_ex.cfuop;
    assign ex_csrop        = r_ex.csrop;
    assign ex_rf_en        = r_ex.rf_en;
    assign ex_dm_wr_en     = r_ex.dm_wr_en;
    assign ex_dm_rd_en     = r_ex.dm_rd_en;
    assign ex_csr_wr_en    = r_ex.csr_wr_en;
    assign ex_opr_a_sel    = r_ex.opr_a_sel;
    assign ex_opr_b_sel    = r_ex.opr_b_sel;
    assign ex_wb_sel       = r_ex.wb_sel;
    assign ex_pc           = r_ex.pc;
    assign ex_rdata1       = r_ex.rdata1;
    assign ex_rdata2       = r_ex.rdata2;
    assign ex_imm          = r_ex.imm;
    assign ex_rs1          = r_ex.rs1;
    assign ex_rs2          = r_ex.rs2;
    assign ex_rd           = r_ex.rd;
    assign perf_lu_bubbles = r_perf;

endmodule
